adc_stream_unpacker: RTL and testbench
======================================

# adc_stream_unpacker

AXI-Stream slave that terminates the 128-bit ADC record stream produced by the trigger/capture block and re-emits it as a 64-bit AXI-Stream suitable for the DMA writer. Each record's marker is checked. Contiguous sample indices are grouped into events, and discontinuities and input overflows are flagged. Bursts are absorbed in an internal FIFO, and statistics counters are exposed for the register map.

## Interface
- `FIFO_DEPTH`, 16 — record FIFO depth in records; must be a power of two, ≥4.
- `MARKER`, 16'hA1B2 — expected value of record bits [15:0].
- `aclk` in 1 — single clock for the whole block.
- `aresetn` in 1 — reset, asynchronous, active-low.
- `s_axis_tvalid` in 1 — input record valid.
- `s_axis_tready` out 1 — input ready.
- `s_axis_tdata` in 128 — input record, laid out as follows:
  - [127:64] sample index
  - [63:48] channel A
  - [47:32] channel B
  - [31:16] sum
  - [15:0] marker
- `m_axis_tvalid` out 1 — output beat valid.
- `m_axis_tready` in 1 — downstream ready.
- `m_axis_tdata` out 64 — output beat.
- `m_axis_tuser` out 1 — start-of-event; set on beat0 of an event's first record.
- `m_axis_tlast` out 1 — set on beat1 of every record.
- `clear_counters` in 1 — synchronous pulse that zeroes all statistics counters.
- `records_count` out 32 — records accepted into the FIFO.
- `events_count` out 32 — events started.
- `bad_marker_count` out 16 — records discarded for a wrong marker.
- `overflow_count` out 32 — cycles with `s_axis_tvalid=1` and `s_axis_tready=0`.

## Operation
- **Input accept.** A record is accepted on `s_axis_tvalid && s_axis_tready`.
  - `s_axis_tready` is `!fifo_full`, and is forced to 0 while `aresetn` is low.
  - The upstream producer may ignore `s_axis_tready`. Every `tvalid && !tready` cycle increments `overflow_count` (saturating) and sets the sticky `ovf_pending`.
- **Marker check.** If record bits [15:0] ≠ `MARKER`, the record is discarded.
  - `bad_marker_count` increments (saturating).
  - Neither `prev_index` nor `ovf_pending` is changed.
- **Event segmentation**, applied at FIFO write.
  - `gap` = a previous record exists and index ≠ `prev_index + 1`, computed mod 2^64. The wrap from FFFF…F to 0 is contiguous.
  - `soe` = no previous record since reset, or `gap`.
  - On `soe`, `events_count` increments.
  - Every written record increments `records_count` and updates `prev_index`.
  - The written record captures `ovf` = `ovf_pending`, and `ovf_pending` then clears.
- **FIFO entry.** 115 bits: {index[63:0], A, B, sum, soe, gap, ovf}.
- **Output FSM.** States IDLE → BEAT0 → BEAT1 → (BEAT0 if the FIFO is non-empty, else IDLE).
  - BEAT0: `tdata` = index, `tuser` = soe, `tlast` = 0.
  - BEAT1: `tdata` = {A, B, sum, 13'b0, ovf, gap, soe}, `tuser` = 0, `tlast` = 1.
  - The FIFO entry is popped on the BEAT1 handshake.
  - While `m_axis_tvalid && !m_axis_tready`, all `m_axis_*` outputs hold stable.
- **Counter clear.** `clear_counters` zeroes all four counters in the same cycle it is seen. It has priority over a simultaneous increment. FIFO contents, `prev_index` and `ovf_pending` are not affected.
- **Reset values.** `m_axis_tvalid`, `tuser`, `tlast`, `tdata` = 0; all counters = 0; FIFO empty; FSM in IDLE; `ovf_pending` = 0; no `prev_index`.
- **Reset mid-operation.** Asserting reset mid-operation drops FIFO contents and any in-flight beat immediately. After reset, the first record is `soe` with `gap`=0.

## Timing
- The FIFO write registers on the accept edge.
- Latency to `m_axis_tvalid` for beat0 of a record accepted into an empty FIFO, in idle state: 2 cycles.
- With `m_axis_tready` held high, BEAT1 directly follows BEAT0.
- Output throughput is 1 record per 2 cycles.
  - Sustained input at 1 record/cycle fills the FIFO after about 2·`FIFO_DEPTH` records, after which overflows are counted.
- Full FIFO with a simultaneous pop: `s_axis_tready` stays 0 that cycle, with no pass-through. It rises the cycle after the pop.
- An overflow cycle and an accepted record never coincide. `ovf_pending` set in cycle N is captured by the first record accepted at N+1 or later.
- Counter outputs are registered and update 1 cycle after the causing event.

## Configuration
- `ADC_UNPACK_MARKER_CHECK_EN` defined: marker check active as described.
- Not defined: the marker field is ignored, every handshaken record is written, and `bad_marker_count` is tied to 0.

## Structure
- The package `adc_stream_pkg` holds:
  - record field offsets/widths;
  - the default `MARKER`;
  - the flag bit indices SOE=0, GAP=1, OVF=2;
  - the FIFO entry width constant (115);
  - the output FSM state enum.
- One sub-module: `adc_rec_fifo`, a synchronous single-clock FIFO with width and depth parameters and full/empty/count.
  - Segmentation, counters and the FSM stay in the top module.

## Test plan
- **Contiguous records.** Indices 100,101,102 with marker A1B2, `m_axis_tready`=1 → 6 beats.
  - First beat: `tuser`=1.
  - Beat1 flags: 001, 000, 000.
  - `records_count`=3, `events_count`=1.
- **Gap and wrap.** Indices FFFF_FFFF_FFFF_FFFF, 0, 5 → flags: soe (first), none (wrap), soe|gap. `events_count`=2.
- **Bad marker.** Marker 0x1234 between indices 7 and 8 → record dropped, `bad_marker_count`=1, index 8 not flagged gap.
  - Without the macro: record emitted, count 0.
- **Backpressure overflow.**
  - `FIFO_DEPTH`=16, continuous input with `m_axis_tready`=0 → 16 records stored, then `s_axis_tready`=0, and each further valid cycle increments `overflow_count`.
  - After release, the first new record carries ovf=1.
- **Output stall.** `m_axis_tready` toggled 0/1 every cycle → `tdata`/`tuser`/`tlast` constant while stalled, with no beat lost or duplicated.
- **Reset / clear.**
  - `clear_counters` asserted together with a record accept → counters read 0.
  - `aresetn` low mid-BEAT1 → all outputs 0, FIFO empty. The next record after reset has soe=1, gap=0.

Source files
------------

// File: rtl/adc_stream_pkg.sv
// Shared definitions for the ADC record unpacker: input record layout,
// default marker, output flag bit positions, FIFO entry format and the
// output FSM state encoding.
package adc_stream_pkg;

  localparam int IDX_LSB = 64;
  localparam int IDX_W   = 64;
  localparam int CHA_LSB = 48;
  localparam int CHB_LSB = 32;
  localparam int SUM_LSB = 16;
  localparam int MRK_LSB = 0;
  localparam int FIELD_W = 16;

  localparam logic [15:0] MARKER_DEFAULT = 16'hA1B2;

  localparam int FLAG_SOE = 0;
  localparam int FLAG_GAP = 1;
  localparam int FLAG_OVF = 2;

  localparam int ENTRY_W = 115;

  typedef struct packed {
    logic [63:0] index;
    logic [15:0] ch_a;
    logic [15:0] ch_b;
    logic [15:0] sum;
    logic        soe;
    logic        gap;
    logic        ovf;
  } rec_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } out_state_t;

endpackage

// File: rtl/adc_rec_fifo.sv
// Single-clock record FIFO with show-ahead read: rd_data is the head entry
// whenever the FIFO is non-empty. Writes to a full FIFO and reads from an
// empty FIFO are ignored.
module adc_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage array, no reset needed since empty gates every read
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/adc_stream_unpacker.sv
// 128-bit ADC record stream to 64-bit two-beat stream, with marker check,
// event segmentation on index discontinuity, overflow flagging and
// statistics counters.
// Optional feature macro: ADC_UNPACK_MARKER_CHECK_EN (marker check and
// bad_marker_count); when undefined every handshaken record is written.
//
// Output FSM states:
//   state    | meaning
//   ST_IDLE  | nothing to send, FIFO empty
//   ST_BEAT0 | presenting head record index, tuser = soe
//   ST_BEAT1 | presenting head record samples + flags, tlast = 1; pop on handshake
module adc_stream_unpacker
  import adc_stream_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] MARKER     = MARKER_DEFAULT
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [127:0] s_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [63:0]  m_axis_tdata,
  output logic         m_axis_tuser,
  output logic         m_axis_tlast,
  input  logic         clear_counters,
  output logic [31:0]  records_count,
  output logic [31:0]  events_count,
  output logic [15:0]  bad_marker_count,
  output logic [31:0]  overflow_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rec_entry_t  wr_entry;
  rec_entry_t  head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        accept;
  logic        ovf_cycle;
  logic        marker_ok;
  logic        wr_en;
  logic        rd_en;
  logic [63:0] in_index;
  logic [63:0] prev_index;
  logic        prev_valid;
  logic        ovf_pending;
  logic        gap;
  logic        soe;
  logic [15:0] beat1_flags;
  out_state_t  state;
  out_state_t  state_nxt;

  assign s_axis_tready = aresetn & ~fifo_full;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign ovf_cycle     = s_axis_tvalid & ~s_axis_tready;

`ifdef ADC_UNPACK_MARKER_CHECK_EN
  logic bad_rec;
  assign marker_ok = (s_axis_tdata[MRK_LSB +: FIELD_W] == MARKER);
  assign bad_rec   = accept & ~marker_ok;
`else
  logic unused_marker;
  assign marker_ok     = 1'b1;
  assign unused_marker = (s_axis_tdata[MRK_LSB +: FIELD_W] == MARKER);
`endif

  assign wr_en    = accept & marker_ok;
  assign in_index = s_axis_tdata[IDX_LSB +: IDX_W];
  // unsigned 64-bit add wraps, so FFFF..F -> 0 counts as contiguous
  assign gap      = prev_valid && (in_index != prev_index + 64'd1);
  assign soe      = ~prev_valid | gap;

  assign wr_entry.index = in_index;
  assign wr_entry.ch_a  = s_axis_tdata[CHA_LSB +: FIELD_W];
  assign wr_entry.ch_b  = s_axis_tdata[CHB_LSB +: FIELD_W];
  assign wr_entry.sum   = s_axis_tdata[SUM_LSB +: FIELD_W];
  assign wr_entry.soe   = soe;
  assign wr_entry.gap   = gap;
  assign wr_entry.ovf   = ovf_pending;

  adc_rec_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // segmentation history and sticky overflow; bad-marker records touch neither
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prev_valid  <= 1'b0;
      prev_index  <= '0;
      ovf_pending <= 1'b0;
    end else begin
      if (wr_en) begin
        prev_valid <= 1'b1;
        prev_index <= in_index;
      end
      if (ovf_cycle)  ovf_pending <= 1'b1;
      else if (wr_en) ovf_pending <= 1'b0;
    end
  end

  // saturating statistics counters, clear wins over increment
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      records_count  <= '0;
      events_count   <= '0;
      overflow_count <= '0;
    end else if (clear_counters) begin
      records_count  <= '0;
      events_count   <= '0;
      overflow_count <= '0;
    end else begin
      if (wr_en && ~&records_count)         records_count  <= records_count + 1'b1;
      if (wr_en && soe && ~&events_count)   events_count   <= events_count + 1'b1;
      if (ovf_cycle && ~&overflow_count)    overflow_count <= overflow_count + 1'b1;
    end
  end

`ifdef ADC_UNPACK_MARKER_CHECK_EN
  // bad-marker counter, same clear/saturation rules as the others
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                               bad_marker_count <= '0;
    else if (clear_counters)                    bad_marker_count <= '0;
    else if (bad_rec && ~&bad_marker_count)     bad_marker_count <= bad_marker_count + 1'b1;
  end
`else
  assign bad_marker_count = '0;
`endif

  // output FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // next state and beat outputs; outputs depend only on state and FIFO head,
  // both of which are frozen while a beat is stalled
  always_comb begin
    state_nxt     = state;
    rd_en         = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = 1'b0;
    m_axis_tlast  = 1'b0;
    beat1_flags           = '0;
    beat1_flags[FLAG_SOE] = head.soe;
    beat1_flags[FLAG_GAP] = head.gap;
    beat1_flags[FLAG_OVF] = head.ovf;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nxt = ST_BEAT0;
      end
      ST_BEAT0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = head.index;
        m_axis_tuser  = head.soe;
        if (m_axis_tready) state_nxt = ST_BEAT1;
      end
      ST_BEAT1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {head.ch_a, head.ch_b, head.sum, beat1_flags};
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) begin
          rd_en     = 1'b1;
          state_nxt = (fifo_count > CW'(1) || wr_en) ? ST_BEAT0 : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_stream_unpacker.sv
// Scoreboard bench for adc_stream_unpacker: stimulus pushes expected beats,
// a negedge monitor pops and compares, and tracks counters/occupancy.
module tb_adc_stream_unpacker;

  localparam int          DEPTH = 16;
  localparam logic [15:0] MRK   = 16'hA1B2;
  localparam logic [15:0] BAD   = 16'h1234;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [127:0] s_tdata = '0;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic [63:0]  m_tdata;
  logic         m_tuser;
  logic         m_tlast;
  logic         clear = 1'b0;
  logic [31:0]  records_count;
  logic [31:0]  events_count;
  logic [15:0]  bad_marker_count;
  logic [31:0]  overflow_count;

  always #5 aclk = ~aclk;

  adc_stream_unpacker #(.FIFO_DEPTH(DEPTH), .MARKER(MRK)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .s_axis_tdata     (s_tdata),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tuser     (m_tuser),
    .m_axis_tlast     (m_tlast),
    .clear_counters   (clear),
    .records_count    (records_count),
    .events_count     (events_count),
    .bad_marker_count (bad_marker_count),
    .overflow_count   (overflow_count)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        user;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  // reference model state
  logic        has_prev = 1'b0;
  logic [63:0] prev_idx = '0;
  logic        ovf_pend = 1'b0;
  int          occ = 0;
  logic [31:0] rec_exp = '0, evt_exp = '0, ovf_exp = '0;
  logic [15:0] bad_exp = '0;
  logic        stall_prev = 1'b0;
  logic [63:0] p_tdata;
  logic        p_tuser, p_tlast;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard / model, evaluated mid-cycle
  always @(negedge aclk) begin
    logic        mok, gap, soe;
    logic [63:0] idx;
    logic        inc_rec, inc_evt, inc_bad, inc_ovf;
    beat_t       got, exp;
    if (!aresetn) begin
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tuser_tlast", {m_tuser, m_tlast}, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_counters", {records_count, events_count, bad_marker_count, overflow_count}, 0);
      exp_q.delete();
      occ = 0; has_prev = 0; ovf_pend = 0; stall_prev = 0;
      rec_exp = 0; evt_exp = 0; bad_exp = 0; ovf_exp = 0;
    end else begin
      chk("records_count", records_count, rec_exp);
      chk("events_count", events_count, evt_exp);
      chk("bad_marker_count", bad_marker_count, bad_exp);
      chk("overflow_count", overflow_count, ovf_exp);
      chk("s_tready", s_tready, (occ < DEPTH));
      if (stall_prev) begin
        chk("stall_hold", {m_tvalid, m_tdata, m_tuser, m_tlast}, {1'b1, p_tdata, p_tuser, p_tlast});
      end
      inc_rec = 0; inc_evt = 0; inc_bad = 0; inc_ovf = 0;
      if (s_tvalid && s_tready) begin
`ifdef ADC_UNPACK_MARKER_CHECK_EN
        mok = (s_tdata[15:0] == MRK);
`else
        mok = 1'b1;
`endif
        if (mok) begin
          idx = s_tdata[127:64];
          gap = has_prev && (idx != prev_idx + 64'd1);
          soe = !has_prev || gap;
          exp_q.push_back('{data: idx, user: soe, last: 1'b0});
          exp_q.push_back('{data: {s_tdata[63:16], 13'b0, ovf_pend, gap, soe}, user: 1'b0, last: 1'b1});
          occ++;
          has_prev = 1; prev_idx = idx; ovf_pend = 0;
          inc_rec = 1; inc_evt = soe;
        end else begin
          inc_bad = 1;
        end
      end else if (s_tvalid) begin
        inc_ovf = 1; ovf_pend = 1;
      end
      if (m_tvalid && m_tready) begin
        got = '{data: m_tdata, user: m_tuser, last: m_tlast};
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", got, 0);
        end else begin
          exp = exp_q.pop_front();
          chk(exp.last ? "beat1" : "beat0", got, exp);
        end
        if (m_tlast) occ--;
      end
      if (clear) begin
        rec_exp = 0; evt_exp = 0; bad_exp = 0; ovf_exp = 0;
      end else begin
        rec_exp += 32'(inc_rec); evt_exp += 32'(inc_evt);
        bad_exp += 16'(inc_bad); ovf_exp += 32'(inc_ovf);
      end
      stall_prev = m_tvalid && !m_tready;
      p_tdata = m_tdata; p_tuser = m_tuser; p_tlast = m_tlast;
    end
  end

  // downstream ready pattern: 0 hold rdy_val, 1 toggle, 2 random
  int   rdy_mode = 0;
  logic rdy_val = 1'b0;
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      1:       m_tready = ~m_tready;
      2:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = rdy_val;
    endcase
  end

  function automatic logic [127:0] mk(input logic [63:0] idx, input logic [15:0] mrk);
    logic [15:0] a, b;
    a = 16'($urandom());
    b = 16'($urandom());
    return {idx, a, b, 16'(a + b), mrk};
  endfunction

  task automatic drive(input logic v, input logic [63:0] idx, input logic [15:0] mrk, input logic clr);
    @(posedge aclk);
    #1;
    s_tvalid = v;
    s_tdata  = v ? mk(idx, mrk) : '0;
    clear    = clr;
  endtask

  task automatic send(input logic [63:0] idx, input logic [15:0] mrk);
    drive(1'b1, idx, mrk, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, '0, MRK, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || m_tvalid); i++) @(negedge aclk);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] cur;
    logic        found;
    int          r;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rdy_mode = 0; rdy_val = 1'b1;
    idle();

    // contiguous records, plus idle-to-beat0 latency
    send(64'd100, MRK);
    idle();
    @(negedge aclk); chk("latency_c1", m_tvalid, 0);
    @(negedge aclk); chk("latency_c2", {m_tvalid, m_tuser, m_tdata}, {1'b1, 1'b1, 64'd100});
    send(64'd101, MRK);
    send(64'd102, MRK);
    idle();
    drain("drain_contig");
    chk("contig_counts", {records_count, events_count}, {32'd3, 32'd1});

    // gap and wrap
    send(64'hFFFF_FFFF_FFFF_FFFF, MRK);
    send(64'd0, MRK);
    send(64'd5, MRK);
    idle();
    drain("drain_wrap");
    chk("wrap_events", events_count, 32'd3);

    // bad marker between 7 and 8
    send(64'd7, MRK);
    send(64'd50, BAD);
    send(64'd8, MRK);
    idle();
    drain("drain_bad");
`ifdef ADC_UNPACK_MARKER_CHECK_EN
    chk("bad_count", bad_marker_count, 16'd1);
`else
    chk("bad_count", bad_marker_count, 16'd0);
`endif

    // clear together with an accepted record
    drive(1'b1, 64'd9, MRK, 1'b1);
    idle();
    @(negedge aclk);
    chk("clear_counters", {records_count, events_count, overflow_count}, 0);
    drain("drain_clear");

    // backpressure overflow
    rdy_val = 1'b0;
    idle();
    for (int i = 0; i < 24; i++) send(64'd1000 + 64'(i), MRK);
    idle();
    @(negedge aclk);
    chk("bp_tready", s_tready, 0);
    chk("bp_counts", {records_count, overflow_count}, {32'd16, 32'd8});
    rdy_val = 1'b1;
    repeat (6) idle();
    send(64'd2000, MRK);
    idle();
    drain("drain_bp");

    // output stall with toggling ready
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) send(64'd3000 + 64'(i), MRK);
    idle();
    drain("drain_stall");

    // reset while stalled in beat1
    send(64'd4000, MRK);
    idle();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge aclk);
      found = m_tvalid && m_tlast && !m_tready;
    end
    chk("beat1_reached", found, 1);
    #1 aresetn = 1'b0;
    #1 chk("async_reset_outputs", {m_tvalid, m_tuser, m_tlast, m_tdata, s_tready}, 0);
    rdy_mode = 0; rdy_val = 1'b1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    send(64'd4001, MRK);
    idle();
    drain("drain_after_reset");

    // randomized traffic
    rdy_mode = 2;
    cur = 64'd5000;
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        if ($urandom_range(0, 7) == 0) cur = {32'($urandom()), 32'($urandom())};
        else if ($urandom_range(0, 31) == 0) cur = 64'hFFFF_FFFF_FFFF_FFFE;
        else cur = cur + 64'd1;
        drive(1'b1, cur, ($urandom_range(0, 9) == 0) ? BAD : MRK, ($urandom_range(0, 49) == 0));
      end else begin
        drive(1'b0, '0, MRK, ($urandom_range(0, 49) == 0));
      end
    end
    idle();
    rdy_mode = 0; rdy_val = 1'b1;
    drain("drain_random");
    repeat (2) @(negedge aclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
